// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter types and rotating first-set-bit search
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int unsigned ARB_MAX_WIDTH = 64;
  localparam int unsigned ARB_IDX_W     = $clog2(ARB_MAX_WIDTH);

  // First set bit of req[width-1:0] at or after ptr, wrapping modulo width.
  function automatic logic [ARB_MAX_WIDTH-1:0] rr_first_oht(
    input logic [ARB_MAX_WIDTH-1:0] req,
    input int unsigned              ptr,
    input int unsigned              width
  );
    logic [ARB_MAX_WIDTH-1:0] oht;
    logic                     found;
    int unsigned              pos;
    oht   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < ARB_MAX_WIDTH; i++) begin
      pos = ptr + i;
      if (pos >= width) pos = pos - width;
      if ((i < width) && !found && req[pos[ARB_IDX_W-1:0]]) begin
        oht[pos[ARB_IDX_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
    return oht;
  endfunction

endpackage

// File: rtl/oht2bin.sv
// rtl/oht2bin.sv - one-hot to binary index converter
// IMPLEMENTATION 0: flat OR of indices; 1: two-level tree grouped by SPLIT.
module oht2bin #(
  parameter  int unsigned WIDTH          = 16,
  parameter  int unsigned SPLIT          = 4,
  parameter  int unsigned IMPLEMENTATION = 0,
  localparam int unsigned WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     oht,
  output logic [WIDTH_LOG-1:0] bin
);

  if (IMPLEMENTATION == 0) begin : g_flat
    always_comb begin
      bin = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (oht[i]) bin = bin | WIDTH_LOG'(i);
      end
    end
  end else begin : g_tree
    localparam int unsigned NGRP = (WIDTH + SPLIT - 1) / SPLIT;

    logic [NGRP*SPLIT-1:0] oht_pad;
    logic                  hit;
    int                    loc;

    always_comb begin
      oht_pad              = '0;
      oht_pad[WIDTH-1:0]   = oht;
      bin                  = '0;
      hit                  = 1'b0;
      loc                  = 0;
      // Input is one-hot, so group offset plus local index can be OR-combined.
      for (int g = 0; g < int'(NGRP); g++) begin
        hit = |oht_pad[g*SPLIT +: SPLIT];
        loc = 0;
        for (int j = 0; j < int'(SPLIT); j++) begin
          if (oht_pad[g*SPLIT + j]) loc = loc | j;
        end
        if (hit) bin = bin | WIDTH_LOG'(g * int'(SPLIT) + loc);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant and binary index
// Optional burst lock input enabled by RR_ARBITER_LOCK_EN.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned WIDTH          = 16,
  parameter  int unsigned SPLIT          = 4,
  parameter  int unsigned IMPLEMENTATION = 0,
  localparam int unsigned WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
`ifdef RR_ARBITER_LOCK_EN
  input  logic                 lock,
`endif
  output logic                 gnt_vld,
  input  logic                 gnt_rdy,
  output logic [WIDTH-1:0]     gnt_oht,
  output logic [WIDTH_LOG-1:0] gnt_bin
);

  arb_state_t               state, state_n;
  logic [WIDTH-1:0]         gnt_q, gnt_n;
  logic [WIDTH_LOG-1:0]     ptr_q, ptr_n;
  logic [WIDTH_LOG-1:0]     ptr_adv, xfer_ptr, scan_ptr;
  logic [ARB_MAX_WIDTH-1:0] scan_req, scan_oht;
  logic [WIDTH-1:0]         pick_oht;
  logic                     pick_any;
  logic                     lock_xfer;

`ifdef RR_ARBITER_LOCK_EN
  assign lock_xfer = lock;
`else
  assign lock_xfer = 1'b0;
`endif

  assign ptr_adv  = (gnt_bin == WIDTH_LOG'(WIDTH - 1)) ? '0 : gnt_bin + WIDTH_LOG'(1);
  assign xfer_ptr = lock_xfer ? ptr_q : ptr_adv;
  // On a transfer the scan starts from the post-transfer pointer, so the
  // just-granted requester naturally comes last.
  assign scan_ptr = (state == GRANT) ? xfer_ptr : ptr_q;

  always_comb begin
    scan_req            = '0;
    scan_req[WIDTH-1:0] = req;
  end

  assign scan_oht = rr_first_oht(scan_req, 32'(scan_ptr), WIDTH);
  assign pick_oht = scan_oht[WIDTH-1:0];
  assign pick_any = |scan_oht;

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    ptr_n   = ptr_q;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          gnt_n   = pick_oht;
        end
      end
      GRANT: begin
        if (gnt_rdy) begin
          ptr_n = xfer_ptr;
          if (lock_xfer && |(req & gnt_q)) begin
            gnt_n = gnt_q;
          end else if (pick_any) begin
            gnt_n = pick_oht;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      state <= state_n;
      gnt_q <= gnt_n;
      ptr_q <= ptr_n;
    end
  end

  assign gnt_vld = (state == GRANT);
  assign gnt_oht = gnt_q;

  oht2bin #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_oht2bin (
    .oht (gnt_q),
    .bin (gnt_bin)
  );

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed table-driven bench for rr_arbiter
module tb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        gnt_rdy;
  logic        gnt_vld;
  logic [15:0] gnt_oht;
  logic [3:0]  gnt_bin;
`ifdef RR_ARBITER_LOCK_EN
  logic        lock;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
`ifdef RR_ARBITER_LOCK_EN
    .lock    (lock),
`endif
    .gnt_vld (gnt_vld),
    .gnt_rdy (gnt_rdy),
    .gnt_oht (gnt_oht),
    .gnt_bin (gnt_bin)
  );

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        rdy;
    logic        vld;
    logic [15:0] oht;
    logic [3:0]  bin;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic vld, input logic [15:0] oht, input logic [3:0] bin);
    chk({nm, " vld"}, 32'(gnt_vld), 32'(vld));
    chk({nm, " oht"}, 32'(gnt_oht), 32'(oht));
    chk({nm, " bin"}, 32'(gnt_bin), 32'(bin));
  endtask

  task automatic add(input logic rst, input logic [15:0] r, input logic rdy,
                     input logic vld, input logic [15:0] oht, input logic [3:0] bin);
    vec_t v;
    v.rst = rst; v.req = r; v.rdy = rdy; v.vld = vld; v.oht = oht; v.bin = bin;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    gnt_rdy = 1'b0;
    @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 16'h0000, 4'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [15:0] r, input logic rdy);
    req     = r;
    gnt_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] one;
    rst_n   = 1'b0;
    req     = '0;
    gnt_rdy = 1'b0;
`ifdef RR_ARBITER_LOCK_EN
    lock    = 1'b0;
`endif

    // Idle, single request, drop, lone requester re-granted back-to-back.
    for (int i = 0; i < 5; i++) add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
    add(1'b0, 16'h0010, 1'b1, 1'b1, 16'h0010, 4'd4);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
    add(1'b0, 16'h0010, 1'b1, 1'b1, 16'h0010, 4'd4);
    add(1'b0, 16'h0010, 1'b1, 1'b1, 16'h0010, 4'd4);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
    // Full rotation from reset: 0..15 then 0, no bubbles.
    for (int i = 0; i < 17; i++) begin
      one = 16'h0001 << (i % 16);
      add(i == 0, 16'hFFFF, 1'b1, 1'b1, one, 4'(i % 16));
    end
    // Backpressure holds grant even after the granted bit drops.
    add(1'b1, 16'h0005, 1'b0, 1'b1, 16'h0001, 4'd0);
    add(1'b0, 16'h0005, 1'b0, 1'b1, 16'h0001, 4'd0);
    add(1'b0, 16'h0005, 1'b0, 1'b1, 16'h0001, 4'd0);
    add(1'b0, 16'h0004, 1'b0, 1'b1, 16'h0001, 4'd0);
    add(1'b0, 16'h0004, 1'b1, 1'b1, 16'h0004, 4'd2);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
    // Wrap and fairness after granting index 15.
    add(1'b0, 16'h8000, 1'b1, 1'b1, 16'h8000, 4'd15);
    add(1'b0, 16'h8001, 1'b1, 1'b1, 16'h0001, 4'd0);
    add(1'b0, 16'h8001, 1'b1, 1'b1, 16'h8000, 4'd15);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);

    do_reset();
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].req, vecs[i].rdy);
      chk_out($sformatf("vec%0d", i), vecs[i].vld, vecs[i].oht, vecs[i].bin);
    end

    // Reset mid-grant clears asynchronously and resets the pointer.
    step(16'h0008, 1'b1);
    chk_out("pre3", 1'b1, 16'h0008, 4'd3);
    step(16'h0020, 1'b1);
    chk_out("pre5", 1'b1, 16'h0020, 4'd5);
    gnt_rdy = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 16'h0000, 4'd0);
    #2;
    rst_n = 1'b1;
    step(16'h0000, 1'b1);
    chk_out("no_replay", 1'b0, 16'h0000, 4'd0);
    step(16'h0021, 1'b1);
    chk_out("ptr_reset", 1'b1, 16'h0001, 4'd0);

    // Burst lock: re-grant the same requester while locked.
    do_reset();
`ifdef RR_ARBITER_LOCK_EN
    lock = 1'b1;
    step(16'h0006, 1'b1);
    chk_out("lock_g1", 1'b1, 16'h0002, 4'd1);
    step(16'h0006, 1'b1);
    chk_out("lock_g1_again", 1'b1, 16'h0002, 4'd1);
    lock = 1'b0;
    step(16'h0006, 1'b1);
    chk_out("lock_g2", 1'b1, 16'h0004, 4'd2);
`else
    step(16'h0006, 1'b1);
    chk_out("rr_g1", 1'b1, 16'h0002, 4'd1);
    step(16'h0006, 1'b1);
    chk_out("rr_g2", 1'b1, 16'h0004, 4'd2);
    step(16'h0006, 1'b1);
    chk_out("rr_g1_again", 1'b1, 16'h0002, 4'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter with a registered grant. Sits directly upstream of oht2bin.
- Takes a request vector and issues a one-hot grant, held stable under a valid/ready handshake.
- The grant is converted to a binary index by an internal oht2bin instance.
- Rotating priority is derived from a pointer to the last granted requester, giving fair service to all requesters.

Parameters:
- WIDTH, 16, number of requesters; must be ≥2.
- SPLIT, 4, tree split factor forwarded to oht2bin.
- IMPLEMENTATION, 0, oht2bin implementation select (0 or 1).
- WIDTH_LOG (localparam), $clog2(WIDTH), binary index width.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  WIDTH  request vector; bit i is requester i.
- gnt_vld  output  1  grant valid.
- gnt_rdy  input  1  downstream accepts the grant; a transfer occurs when gnt_vld && gnt_rdy.
- gnt_oht  output  WIDTH  one-hot grant; all zero when gnt_vld=0.
- gnt_bin  output  WIDTH_LOG  binary index of gnt_oht, produced by oht2bin.

Behaviour:
- Reset (async assert, sync deassert handled by the system):
  - gnt_vld=0, gnt_oht='0, gnt_bin=0.
  - Pointer ptr=0, so requester 0 has highest priority after reset.
  - State returns to IDLE.
- States:
  - IDLE: gnt_vld=0.
  - GRANT: gnt_vld=1 and gnt_oht is held.
- IDLE -> GRANT:
  - On a clock edge with |req=1.
  - The winner is the first set bit of req at or after ptr, scanning upward and wrapping modulo WIDTH.
  - gnt_oht is registered, so there is 1 cycle of latency from req to gnt_vld.
- GRANT with gnt_rdy=0:
  - gnt_oht and gnt_bin are held unchanged.
  - The grant is held even if the granted req bit drops; a grant is never withdrawn.
- GRANT with gnt_rdy=1 (transfer):
  - ptr <= (granted index + 1) mod WIDTH.
  - Requests are re-evaluated in the same cycle using the new pointer, excluding the just-granted bit.
  - If any other bit is set, the new grant is issued back-to-back with no bubble.
  - If only the just-granted bit is set, it is re-granted next cycle.
  - If req=0, go to IDLE.
- Wrap-around: after granting index WIDTH-1, ptr=0.
- Invariant: gnt_oht is either zero or exactly one-hot.
- gnt_bin is purely combinational from the gnt_oht register; it has zero latency relative to gnt_oht.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). The pending grant is lost, not replayed.

Optional Feature:
- Macro: RR_ARBITER_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - A transfer with lock=1 leaves ptr unchanged.
  - If the same requester still requests, it is re-granted next cycle ahead of all others; this supports multi-beat bursts.
  - lock is ignored when gnt_vld=0.
- When undefined:
  - No lock port.
  - ptr always advances on transfer.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - a function for rotating first-set-bit search returning a one-hot vector, shared with other arbiters.
- One sub-module: oht2bin, instantiated with WIDTH, SPLIT and IMPLEMENTATION; drives gnt_bin.

Test Plan:
- Reset, idle: req=16'h0000 for 5 cycles after rst_n rises -> gnt_vld=0, gnt_oht=16'h0000, gnt_bin=0 every cycle.
- Single request: req=16'h0010, gnt_rdy=1 -> the next cycle gives gnt_vld=1, gnt_oht=16'h0010, gnt_bin=4. Drop req after the transfer -> gnt_vld=0 the cycle after.
- Full rotation: req=16'hFFFF, gnt_rdy=1 constant -> gnt_bin sequence 0,1,2,...,15,0, one grant per cycle, no bubbles.
- Backpressure: req=16'h0005, gnt_rdy=0 for 3 cycles -> gnt_oht=16'h0001 held, even after req changes to 16'h0004. Then gnt_rdy=1 -> the next grant is 16'h0004, gnt_bin=2.
- Wrap and fairness: after a grant of index 15, req=16'h8001 -> grant 0 first, then 15.
- Reset mid-grant and lock:
  - Assert rst_n=0 while gnt_vld=1 -> gnt_vld=0 without waiting for a clock.
  - With RR_ARBITER_LOCK_EN, req=16'h0006, lock=1 on transfer -> index 1 is granted twice, then index 2.
